// File: rtl/cnu_expand.sv
// Check node output stage: expands a (min1, min2, idx, signs) result into DC
// offset-min-sum check-to-variable messages, streamed Pout lanes per beat.
module cnu_expand #(
  parameter int data_w = 8,
  parameter int idx_w  = 8,
  parameter int DC     = 12,
  parameter int Pout   = 4,
  parameter int OFFSET = 1,
  localparam int NB    = (DC + Pout - 1) / Pout,
  localparam int bw    = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*data_w-1:0]        min_in,
  input  logic [idx_w-1:0]           idx_in,
  input  logic [DC-1:0]              sign_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [(data_w+1)*Pout-1:0] out,
  output logic [bw-1:0]              out_beat,
  output logic                       out_last
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam int                NB_TAB   = 2 ** bw;
  localparam logic [bw-1:0]     LAST_B   = bw'(NB - 1);
  localparam logic [data_w-1:0] OFFSET_C = data_w'(OFFSET);

  state_t              state_q, state_d;
  logic                en_q;
  logic [data_w-1:0]   min1_q, min2_q;
  logic [idx_w-1:0]    idx_q;
  logic [DC-1:0]       sign_q;
  logic                parity_q;
  logic [bw-1:0]       beat_q, beat_d;
  logic                take, fire, last;

  assign out_valid = (state_q == SEND);
  assign last      = out_valid && (beat_q == LAST_B);
  assign fire      = out_valid & out_ready;
  // The last-beat handshake reopens the input so the next word follows with no bubble.
  assign in_ready  = en_q & ((state_q == IDLE) | (fire & last));
  assign take      = in_valid & in_ready;
  assign out_beat  = beat_q;
  assign out_last  = last;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    beat_d  = beat_q;
    if (take) begin
      state_d = SEND;
      beat_d  = '0;
    end else if (fire) begin
      if (last) state_d = IDLE;
      else      beat_d  = beat_q + bw'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      en_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min1_q   <= '0;
      min2_q   <= '0;
      idx_q    <= '0;
      sign_q   <= '0;
      parity_q <= 1'b0;
    end else if (take) begin
      min1_q   <= min_in[data_w-1:0];
      min2_q   <= min_in[2*data_w-1:data_w];
      idx_q    <= idx_in;
      sign_q   <= sign_in;
      parity_q <= ^sign_in;
    end
  end

  logic [data_w-1:0] mag1, mag2;
  assign mag1 = (min1_q >= OFFSET_C) ? min1_q - OFFSET_C : '0;
  assign mag2 = (min2_q >= OFFSET_C) ? min2_q - OFFSET_C : '0;

  // Every (beat, lane) has a fixed edge number, so the table is built with constant indices.
  logic [data_w:0] lane_tab [NB_TAB][Pout];

  for (genvar b = 0; b < NB_TAB; b++) begin : g_beat
    for (genvar k = 0; k < Pout; k++) begin : g_lane
      localparam int E = b * Pout + k;
      if (E < DC) begin : g_edge
        assign lane_tab[b][k] = {parity_q ^ sign_q[E],
                                 (idx_q == idx_w'(E)) ? mag2 : mag1};
      end else begin : g_pad
        assign lane_tab[b][k] = '0;
      end
    end
  end

  always_comb begin
    out = '0;
    if (out_valid) begin
      for (int k = 0; k < Pout; k++) begin
        out[(data_w+1)*k +: data_w+1] = lane_tab[beat_q][k];
      end
    end
  end

endmodule

// File: tb/tb_cnu_expand.sv
// Self-checking bench for cnu_expand: directed scenarios plus randomized words,
// checked against a per-edge arithmetic model of the offset min-sum expansion.
module tb_cnu_expand;

  localparam int DW  = 8;
  localparam int P   = 4;
  localparam int OFF = 1;
  localparam int DCA = 12;
  localparam int DCB = 10;
  localparam int NBA = 3;
  localparam int NBB = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, out_last;
  logic [15:0] min_in;
  logic [7:0]  idx_in;
  logic [11:0] sign_in;
  logic [35:0] out;
  logic [1:0]  out_beat;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [15:0] b_min_in;
  logic [7:0]  b_idx_in;
  logic [9:0]  b_sign_in;
  logic [35:0] b_out;
  logic [1:0]  b_out_beat;

  int errors = 0;
  int checks = 0;

  cnu_expand #(.data_w(8), .idx_w(8), .DC(DCA), .Pout(P), .OFFSET(OFF)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .min_in(min_in), .idx_in(idx_in), .sign_in(sign_in),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .out_beat(out_beat), .out_last(out_last));

  cnu_expand #(.data_w(8), .idx_w(8), .DC(DCB), .Pout(P), .OFFSET(OFF)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .min_in(b_min_in), .idx_in(b_idx_in), .sign_in(b_sign_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out),
    .out_beat(b_out_beat), .out_last(b_out_last));

  // Reference: each edge gets min1 (or min2 at idx) minus the offset, floored at
  // zero, with sign = (odd number of negative inputs) XOR own sign.
  function automatic logic [35:0] exp_beat(int dc, int m1, int m2, int idx,
                                           logic [11:0] sgn, int b);
    int ones, e, raw, mag;
    logic par;
    logic [35:0] r;
    ones = 0;
    r = '0;
    for (int i = 0; i < dc; i++) ones += int'(sgn[i]);
    par = (ones % 2) == 1;
    for (int k = 0; k < P; k++) begin
      e = b * P + k;
      if (e < dc) begin
        raw = (e == idx) ? m2 : m1;
        mag = raw - OFF;
        if (mag < 0) mag = 0;
        r[9*k +: 9] = {par ^ sgn[e], 8'(mag)};
      end
    end
    return r;
  endfunction

  task automatic capture(input int m1, input int m2, input int idx, input logic [11:0] sgn);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    min_in   = {8'(m2), 8'(m1)};
    idx_in   = 8'(idx);
    sign_in  = sgn;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL capture_ready: in_ready=%b expected 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic collect(input string nm, input int m1, input int m2, input int idx,
                         input logic [11:0] sgn, input int stall_beat, input int stall_n,
                         input bit rnd_stall, input bit chain, input int cm1, input int cm2,
                         input int cidx, input logic [11:0] csgn);
    int b, cyc, left;
    logic [35:0] exp;
    b = 0;
    cyc = 0;
    left = stall_n;
    out_ready = 1'b1;
    while (b < NBA && cyc < 40) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s_valid: beat %0d out_valid=%b expected 1", nm, b, out_valid);
      end
      exp = exp_beat(DCA, m1, m2, idx, sgn, b);
      checks++;
      if (out !== exp) begin
        errors++;
        $display("FAIL %s_data: beat %0d out=%h expected %h", nm, b, out, exp);
      end
      checks++;
      if (out_beat !== 2'(b) || out_last !== (b == NBA - 1)) begin
        errors++;
        $display("FAIL %s_beat: out_beat=%0d out_last=%b expected %0d/%b",
                 nm, out_beat, out_last, b, b == NBA - 1);
      end
      if (b == stall_beat && left > 0) begin
        out_ready = 1'b0;
        left--;
      end else if (rnd_stall && $urandom_range(0, 3) == 0) begin
        out_ready = 1'b0;
      end else begin
        out_ready = 1'b1;
        if (b == NBA - 1 && chain) begin
          in_valid = 1'b1;
          min_in   = {8'(cm2), 8'(cm1)};
          idx_in   = 8'(cidx);
          sign_in  = csgn;
          #1;
          checks++;
          if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_chain_ready: in_ready=%b expected 1", nm, in_ready);
          end
        end
        b++;
      end
    end
    if (b != NBA) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: beats accepted=%0d expected %0d", nm, b, NBA);
    end
  endtask

  task automatic end_idle(input string nm);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle: out_valid=%b in_ready=%b expected 0/1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; min_in = '0; idx_in = '0; sign_in = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_min_in = '0; b_idx_in = '0; b_sign_in = '0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out !== '0 || out_beat !== '0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b ready=%b out=%h beat=%0d last=%b expected all 0",
               out_valid, in_ready, out, out_beat, out_last);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b/%b expected 0 before first edge", in_ready, b_in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_enable: in_ready=%b/%b expected 1", in_ready, b_in_ready);
    end
  endtask

  task automatic test_basic();
    capture(5, 9, 6, 12'h000);
    collect("basic", 5, 9, 6, 12'h000, -1, 0, 1'b0, 1'b0, 0, 0, 0, 12'h000);
    end_idle("basic");
  endtask

  task automatic test_sign();
    capture(5, 9, 6, 12'h001);
    collect("sign", 5, 9, 6, 12'h001, -1, 0, 1'b0, 1'b0, 0, 0, 0, 12'h000);
    end_idle("sign");
  endtask

  task automatic test_saturate();
    capture(0, 1, 3, 12'h5A3);
    collect("sat", 0, 1, 3, 12'h5A3, -1, 0, 1'b0, 1'b0, 0, 0, 0, 12'h000);
    end_idle("sat");
  endtask

  task automatic test_stall();
    capture(20, 40, 11, 12'h3C0);
    collect("stall", 20, 40, 11, 12'h3C0, 1, 3, 1'b0, 1'b0, 0, 0, 0, 12'h000);
    end_idle("stall");
  endtask

  task automatic test_back_to_back();
    capture(5, 9, 6, 12'h000);
    collect("b2b_a", 5, 9, 6, 12'h000, -1, 0, 1'b0, 1'b1, 100, 2, 0, 12'hFFF);
    @(posedge clk);
    #1 in_valid = 1'b0;
    collect("b2b_b", 100, 2, 0, 12'hFFF, -1, 0, 1'b0, 1'b0, 0, 0, 0, 12'h000);
    end_idle("b2b");
  endtask

  task automatic test_random();
    int m1, m2, idx, nm1, nm2, nidx;
    logic [11:0] s, ns;
    bit chained, ch;
    chained = 1'b0;
    m1 = $urandom_range(0, 255); m2 = $urandom_range(0, 255);
    idx = $urandom_range(0, 15); s = 12'($urandom);
    for (int i = 0; i < 8; i++) begin
      nm1 = $urandom_range(0, 255); nm2 = $urandom_range(0, 255);
      nidx = $urandom_range(0, 15); ns = 12'($urandom);
      ch = (i < 7) && ($urandom_range(0, 1) == 1);
      if (!chained) capture(m1, m2, idx, s);
      collect("rand", m1, m2, idx, s, -1, 0, 1'b1, ch, nm1, nm2, nidx, ns);
      if (ch) begin
        @(posedge clk);
        #1 in_valid = 1'b0;
      end else begin
        end_idle("rand");
      end
      chained = ch;
      m1 = nm1; m2 = nm2; idx = nidx; s = ns;
    end
  endtask

  task automatic test_dc10();
    int b, cyc;
    logic [35:0] exp;
    @(negedge clk);
    b_in_valid = 1'b1;
    b_min_in   = {8'd3, 8'd7};
    b_idx_in   = 8'd9;
    b_sign_in  = 10'h2A5;
    b_out_ready = 1'b1;
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    b = 0;
    cyc = 0;
    while (b < NBB && cyc < 20) begin
      @(negedge clk);
      cyc++;
      exp = exp_beat(DCB, 7, 3, 9, {2'b00, 10'h2A5}, b);
      checks++;
      if (b_out_valid !== 1'b1 || b_out !== exp || b_out_beat !== 2'(b)) begin
        errors++;
        $display("FAIL dc10_beat: beat %0d valid=%b out=%h obeat=%0d expected 1/%h/%0d",
                 b, b_out_valid, b_out, b_out_beat, exp, b);
      end
      if (b == NBB - 1) begin
        checks++;
        if (b_out[35:18] !== 18'h0 || b_out_last !== 1'b1) begin
          errors++;
          $display("FAIL dc10_pad: lanes2..3=%h last=%b expected 0/1", b_out[35:18], b_out_last);
        end
      end
      b++;
    end
    @(negedge clk);
    checks++;
    if (b_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL dc10_idle: out_valid=%b expected 0", b_out_valid);
    end
  endtask

  task automatic test_reset_mid();
    capture(5, 9, 6, 12'h000);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_beat !== 2'd1) begin
      errors++;
      $display("FAIL rstmid_pre: valid=%b beat=%0d expected 1/1", out_valid, out_beat);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_beat !== 2'd0 || out !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: valid=%b beat=%0d out=%h ready=%b expected 0/0/0/0",
               out_valid, out_beat, out, in_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_release: ready=%b valid=%b expected 0/0", in_ready, out_valid);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_enable: in_ready=%b expected 1", in_ready);
    end
    capture(50, 60, 2, 12'h81F);
    collect("rstmid_fresh", 50, 60, 2, 12'h81F, -1, 0, 1'b0, 1'b0, 0, 0, 0, 12'h000);
    end_idle("rstmid");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_saturate();
    test_stall();
    test_back_to_back();
    test_dc10();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnu_expand.md
Name: cnu_expand

Overview:
- Output stage of the check node unit (CNU), placed after the min-pair merge tree.
- Takes the final reduced result for one check node: min1, min2, the edge index of min1, and the per-edge input signs.
- Expands it into DC check-to-variable messages in sign-magnitude form, with offset min-sum correction applied.
- Streams the messages Pout edges per beat over a valid/ready handshake toward the VNU interconnect.

Parameters:
- data_w, 8, magnitude width of min1/min2 and of each output magnitude
- idx_w, 8, edge index width
- DC, 12, check node degree (total edges); 2 <= DC < 2**idx_w
- Pout, 4, edges emitted per output beat
- OFFSET, 1, offset subtracted from each magnitude, saturating at 0
- Derived: NB = ceil(DC/Pout) beats per check node; bw = clog2(NB), minimum 1

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept an input word
- min_in  input  2*data_w  [data_w-1:0]=min1, [2*data_w-1:data_w]=min2
- idx_in  input  idx_w  edge index of min1
- sign_in  input  DC  sign of incoming v2c message per edge (1 = negative)
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts beat
- out  output  (data_w+1)*Pout  lane k at [(data_w+1)*k +: data_w+1]; MSB = sign, low data_w bits = magnitude
- out_beat  output  bw  beat number 0..NB-1
- out_last  output  1  high on beat NB-1

Behaviour:
- One clock domain. All state registers reset asynchronously when rst=0.
- Reset values: out_valid=0, out=0, out_beat=0, out_last=0, in_ready=0, state=IDLE.
- in_ready comes from a registered enable. It is 0 while rst is low and becomes 1 on the first clk edge after release.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SEND: out_valid=1.
- Capture: on in_valid & in_ready at edge T, register min1, min2, idx and sign_in. Also register parity = XOR of all DC sign bits. Set beat=0 and state=SEND.
- First out_valid appears in the cycle following edge T (latency 1).
- Lane k of beat b carries edge e = b*Pout + k:
  - raw magnitude = min2 if e == idx, otherwise min1
  - mag = raw - OFFSET if raw >= OFFSET, otherwise 0; no wrap
  - sign = parity XOR sign[e]
  - if e >= DC (padding lanes on the final beat), the whole lane = 0
- out, out_beat and out_last are registered or derived only from registered state, so there is no combinational path from in_* to out_*.
- Backpressure: while out_valid=1 and out_ready=0, out, out_beat and out_last hold stable.
- On out_valid & out_ready:
  - if not last: beat increments by 1.
  - if last and in_valid=1: the next word is captured in the same cycle (in_ready is also 1 during the last-beat handshake), and beat 0 of the new word follows with no bubble.
  - if last and in_valid=0: return to IDLE.
- in_ready = (state==IDLE) OR (out_valid & out_ready & out_last), gated by the reset enable.
- idx_in >= DC: no edge selects min2; every edge uses min1. This is not an error.
- min2 < min1 is not checked; values pass through unchanged.
- in_valid while in_ready=0 is ignored. The upstream source must hold its word until in_ready is seen.
- Reset asserted mid-SEND: out_valid drops to 0 immediately (asynchronously). The partial word is discarded and not resumed after release.

Test Plan:
- DC=12, Pout=4, OFFSET=1; input min1=5, min2=9, idx=6, sign_in=0 -> 3 beats, all signs 0, all magnitudes 4 except beat1 lane2 = 8; out_last only on beat2; first out_valid one cycle after capture.
- sign_in=12'h001, otherwise as the first test -> parity=1; edge0 sign=0, edges 1..11 sign=1; magnitudes unchanged.
- min1=0, min2=1, idx=3 -> all magnitudes 0, including edge 3 (saturation, no wrap to 255).
- Hold out_ready=0 for 3 cycles at beat1 -> out and out_beat stay at 1 and unchanged; after release, beat2 follows and total beat count is 3.
- in_valid held high with word B during the last-beat handshake of word A -> B captured on that edge; the next cycle is B beat0 with out_valid continuous.
- DC=10, Pout=4 -> beat2 lanes 2..3 are all-zero.
- rst driven low during beat1 -> out_valid=0 with no clock edge needed; after release in_ready=0 for one cycle, then 1, then a fresh word starts at beat0.
